// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic operand feeder.
// Holds array defaults, feeder FSM encoding and step-counter width.
package systolic_pkg;

   localparam int N_DIM  = 4;
   localparam int ELEM_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FEED = 2'd1,
      DONE = 2'd2
   } feed_state_t;

   // Width of a counter that spans steps 0 .. 2n-2.
   function automatic int step_w(input int n);
      int w;
      w = $clog2(2 * n - 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/operand_skew_feeder_if.sv
// Edge bundle between the operand feeder and the systolic array.
// master: feeder side (drives edges/valids/status); slave: array side.
interface operand_skew_feeder_if
   import systolic_pkg::*;
#(
   parameter int N  = N_DIM,
   parameter int DW = ELEM_W
);

   logic                   start;
   logic                   array_ready;
   logic [N-1:0][DW-1:0]   a_edge;
   logic [N-1:0][DW-1:0]   b_edge;
   logic [N-1:0]           a_valid;
   logic [N-1:0]           b_valid;
   logic                   clear_acc;
   logic                   busy;
   logic                   feed_done;

   modport master (
      input  start,
      input  array_ready,
      output a_edge,
      output b_edge,
      output a_valid,
      output b_valid,
      output clear_acc,
      output busy,
      output feed_done
   );

   modport slave (
      output start,
      output array_ready,
      input  a_edge,
      input  b_edge,
      input  a_valid,
      input  b_valid,
      input  clear_acc,
      input  busy,
      input  feed_done
   );

endinterface

// File: rtl/skew_lane.sv
// One skewed feed lane: N-element snapshot, lane index LANE, and a
// registered element/valid chosen by k = step - LANE.
// Ports: load (take din), upd (refresh output), blank (force 0),
// step (step being presented next), din, elem, valid.
module skew_lane
   import systolic_pkg::*;
#(
   parameter int N    = N_DIM,
   parameter int DW   = ELEM_W,
   parameter int LANE = 0,
   parameter int TW   = step_w(N)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            load,
   input  logic            upd,
   input  logic            blank,
   input  logic [TW-1:0]   step,
   input  logic [N*DW-1:0] din,
   output logic [DW-1:0]   elem,
   output logic            valid
);

   logic [N*DW-1:0] snap_d, snap_q;
   logic [DW-1:0]   elem_d, elem_q;
   logic            valid_d, valid_q;
   logic [DW-1:0]   sel;
   logic            hit;

   // The first step is selected from din directly, so the element
   // leaves on the same edge that captures the snapshot.
   always_comb begin
      snap_d = load ? din : snap_q;
   end

   always_comb begin
      sel = '0;
      hit = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (int'(step) == LANE + k) begin
            sel = snap_d[DW*(N-k)-1 -: DW];
            hit = 1'b1;
         end
      end
   end

   always_comb begin
      elem_d  = elem_q;
      valid_d = valid_q;
      if (upd) begin
         elem_d  = blank ? '0 : sel;
         valid_d = !blank && hit;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         snap_q  <= '0;
         elem_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         snap_q  <= snap_d;
         elem_q  <= elem_d;
         valid_q <= valid_d;
      end
   end

   assign elem  = elem_q;
   assign valid = valid_q;

endmodule

// File: rtl/operand_skew_feeder.sv
// Feeds snapshotted A rows / B columns into the systolic array edges
// with lane i delayed i steps. FSM IDLE->FEED->DONE->IDLE.
// Ports: clk, reset_n, start, a_rows, b_cols, array_ready in;
// a_edge, b_edge, a_valid, b_valid, clear_acc, busy, feed_done out.
// Macro FEEDER_STALL_EN: when defined array_ready stalls the feed;
// when undefined array_ready is ignored (treated as 1).
module operand_skew_feeder
   import systolic_pkg::*;
#(
   parameter int N  = N_DIM,
   parameter int DW = ELEM_W
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [N-1:0][N*DW-1:0] a_rows,
   input  logic [N-1:0][N*DW-1:0] b_cols,
   input  logic                   array_ready,
   output logic [N-1:0][DW-1:0]   a_edge,
   output logic [N-1:0][DW-1:0]   b_edge,
   output logic [N-1:0]           a_valid,
   output logic [N-1:0]           b_valid,
   output logic                   clear_acc,
   output logic                   busy,
   output logic                   feed_done
);

   localparam int TW = step_w(N);
   localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_FEED = FEED;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]    state_d, state_q;
   logic [TW-1:0] t_d, t_q;
   logic          clear_d, clear_q;
   logic          busy_d, busy_q;
   logic          done_d, done_q;
   logic          adv;
   logic          load;
   logic          upd;
   logic          blank;
   logic [TW-1:0] step_nxt;

`ifdef FEEDER_STALL_EN
   assign adv = array_ready;
`else
   logic unused_ready;
   assign unused_ready = array_ready;
   assign adv = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      clear_d = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      load    = 1'b0;
      upd     = 1'b0;
      blank   = 1'b0;
      unique case (1'b1)
         (state_q == S_IDLE): begin
            if (start) begin
               load    = 1'b1;
               upd     = 1'b1;
               t_d     = '0;
               clear_d = 1'b1;
               busy_d  = 1'b1;
               state_d = S_FEED;
            end
         end
         (state_q == S_FEED): begin
            if (adv) begin
               upd = 1'b1;
               if (t_q == T_LAST) begin
                  blank   = 1'b1;
                  t_d     = '0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  t_d = t_q + TW'(1);
               end
            end
         end
         (state_q == S_DONE): begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            t_d     = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Lanes register the step that becomes visible after this edge.
   assign step_nxt = load ? '0 : t_q + TW'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         clear_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         clear_q <= clear_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      skew_lane #(
         .N    (N),
         .DW   (DW),
         .LANE (i),
         .TW   (TW)
      ) u_a (
         .clk     (clk),
         .reset_n (reset_n),
         .load    (load),
         .upd     (upd),
         .blank   (blank),
         .step    (step_nxt),
         .din     (a_rows[i]),
         .elem    (a_edge[i]),
         .valid   (a_valid[i])
      );

      skew_lane #(
         .N    (N),
         .DW   (DW),
         .LANE (i),
         .TW   (TW)
      ) u_b (
         .clk     (clk),
         .reset_n (reset_n),
         .load    (load),
         .upd     (upd),
         .blank   (blank),
         .step    (step_nxt),
         .din     (b_cols[i]),
         .elem    (b_edge[i]),
         .valid   (b_valid[i])
      );
   end

   assign clear_acc = clear_q;
   assign busy      = busy_q;
   assign feed_done = done_q;

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Directed bench for operand_skew_feeder: table-driven feed vectors,
// start re-pulse, stall (when FEEDER_STALL_EN) and async reset.
module tb_operand_skew_feeder;
   import systolic_pkg::*;

   localparam int N  = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [N-1:0][N*DW-1:0] a_rows;
   logic [N-1:0][N*DW-1:0] b_cols;

   always #5 clk = ~clk;

   operand_skew_feeder_if #(.N(N), .DW(DW)) bus ();

   operand_skew_feeder #(.N(N), .DW(DW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (bus.start),
      .a_rows      (a_rows),
      .b_cols      (b_cols),
      .array_ready (bus.array_ready),
      .a_edge      (bus.a_edge),
      .b_edge      (bus.b_edge),
      .a_valid     (bus.a_valid),
      .b_valid     (bus.b_valid),
      .clear_acc   (bus.clear_acc),
      .busy        (bus.busy),
      .feed_done   (bus.feed_done)
   );

   typedef struct {
      logic [31:0] a_e;
      logic [3:0]  a_v;
      logic [31:0] b_e;
      logic [3:0]  b_v;
      logic        clr;
      logic        bsy;
      logic        dn;
   } vec_t;

   vec_t tbl [9];
   int total  = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic load_default();
      a_rows[0] = 32'h01020304;
      a_rows[1] = 32'h05060708;
      a_rows[2] = 32'h090A0B0C;
      a_rows[3] = 32'h0D0E0F10;
      b_cols[0] = 32'hF1F2F3F4;
      b_cols[1] = 32'hC1C2C3C4;
      b_cols[2] = 32'hA1A2A3A4;
      b_cols[3] = 32'hE1E2E3E4;
   endtask

   // Called at a negedge with the block idle; edge E is the next posedge.
   task automatic run_table(input bit repulse, input string tag);
      bus.start = 1'b1;
      for (int j = 0; j < 9; j++) begin
         @(negedge clk);
         if (j == 0) bus.start = 1'b0;
         chk($sformatf("%s a_edge[%0d]", tag, j), 64'(bus.a_edge), 64'(tbl[j].a_e));
         chk($sformatf("%s a_valid[%0d]", tag, j), 64'(bus.a_valid), 64'(tbl[j].a_v));
         chk($sformatf("%s b_edge[%0d]", tag, j), 64'(bus.b_edge), 64'(tbl[j].b_e));
         chk($sformatf("%s b_valid[%0d]", tag, j), 64'(bus.b_valid), 64'(tbl[j].b_v));
         chk($sformatf("%s clear_acc[%0d]", tag, j), 64'(bus.clear_acc), 64'(tbl[j].clr));
         chk($sformatf("%s busy[%0d]", tag, j), 64'(bus.busy), 64'(tbl[j].bsy));
         chk($sformatf("%s feed_done[%0d]", tag, j), 64'(bus.feed_done), 64'(tbl[j].dn));
         if (repulse && j == 2) begin
            bus.start = 1'b1;
            a_rows[0] = 32'hDEADBEEF;
            a_rows[3] = 32'h55667788;
         end
         if (repulse && j == 3) bus.start = 1'b0;
      end
      load_default();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " a_edge"}, 64'(bus.a_edge), 64'd0);
      chk({tag, " b_edge"}, 64'(bus.b_edge), 64'd0);
      chk({tag, " a_valid"}, 64'(bus.a_valid), 64'd0);
      chk({tag, " b_valid"}, 64'(bus.b_valid), 64'd0);
      chk({tag, " clear_acc"}, 64'(bus.clear_acc), 64'd0);
      chk({tag, " busy"}, 64'(bus.busy), 64'd0);
      chk({tag, " feed_done"}, 64'(bus.feed_done), 64'd0);
   endtask

   initial begin
      tbl[0] = '{32'h00000001, 4'b0001, 32'h000000F1, 4'b0001, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{32'h00000502, 4'b0011, 32'h0000C1F2, 4'b0011, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{32'h00090603, 4'b0111, 32'h00A1C2F3, 4'b0111, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{32'h0D0A0704, 4'b1111, 32'hE1A2C3F4, 4'b1111, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{32'h0E0B0800, 4'b1110, 32'hE2A3C400, 4'b1110, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{32'h0F0C0000, 4'b1100, 32'hE3A40000, 4'b1100, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{32'h10000000, 4'b1000, 32'hE4000000, 4'b1000, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{32'h00000000, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 1'b1, 1'b1};
      tbl[8] = '{32'h00000000, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b0};

      load_default();
      bus.start = 1'b0;
`ifdef FEEDER_STALL_EN
      bus.array_ready = 1'b1;
`else
      bus.array_ready = 1'b0;
`endif

      #1;
      chk_all_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      run_table(1'b0, "basic");
      @(negedge clk);
      run_table(1'b1, "repulse");
      @(negedge clk);

`ifdef FEEDER_STALL_EN
      begin
         logic [7:0] exp0 [10];
         exp0 = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h03,
                  8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
         bus.start = 1'b1;
         for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 0) bus.start = 1'b0;
            chk($sformatf("stall a_edge0[%0d]", j), 64'(bus.a_edge[0]), 64'(exp0[j]));
            chk($sformatf("stall feed_done[%0d]", j), 64'(bus.feed_done), 64'(j == 9));
            if (j == 2) bus.array_ready = 1'b0;
            if (j == 4) bus.array_ready = 1'b1;
         end
         @(negedge clk);
         chk("stall idle busy", 64'(bus.busy), 64'd0);
      end
`endif

      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre-reset busy", 64'(bus.busy), 64'd1);
      chk("pre-reset a_edge", 64'(bus.a_edge), 64'h0D0A0704);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk_all_zero("async reset");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("post-reset idle");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
